mem_reinit_ctrl: RTL and testbench
==================================

# mem_reinit_ctrl

Write-port controller for the single-clock block RAM (simple dual-port, registered read, `WID_MEM` x `DEPTH_MEM`). It shares the RAM write port between a user writer and a reinitialization engine. On `start`, the engine streams a full image from `init_data` into every address 0..`DEPTH_MEM`-1 while user writes are blocked, then returns the port to the user. The block sits between the design top and the memory instance; the read port passes through.

## Interface
Parameters:
- `WID_MEM`, 3, RAM word width
- `DEPTH_MEM`, 4096, RAM depth; must be a power of two, >= 2
- `ADDR_W`, 32, address port width (matches RAM address ports)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin reinitialization
- `busy`  out  1  high while a reinit is in progress
- `done`  out  1  one-cycle pulse when the last word has been written
- `init_valid`  in  1  init stream word valid
- `init_ready`  out  1  init stream ready
- `init_data`  in  `WID_MEM`  init stream word
- `usr_we`  in  1  user write request
- `usr_waddr`  in  `ADDR_W`  user write address
- `usr_din`  in  `WID_MEM`  user write data
- `usr_drop`  out  1  pulse: the user write from the previous cycle was discarded
- `usr_raddr`  in  `ADDR_W`  user read address
- `mem_we`  out  1  RAM write enable
- `mem_waddr`  out  `ADDR_W`  RAM write address
- `mem_din`  out  `WID_MEM`  RAM write data
- `mem_raddr`  out  `ADDR_W`  RAM read address

## Operation
- States: `IDLE`, `FILL`, `DONE`.
- `IDLE`:
  - `usr_we` is forwarded to the RAM write port: `mem_we` = 1, `mem_waddr` = `usr_waddr`, `mem_din` = `usr_din`.
  - `start` moves the block to `FILL` and clears the address counter `cnt` to 0.
- `FILL`:
  - `init_ready` = 1.
  - Each beat with `init_valid` high writes `init_data` to address `cnt`, then increments `cnt`.
  - The beat accepted with `cnt` == `DEPTH_MEM`-1 moves the block to `DONE`.
  - A `usr_we` in `FILL` or `DONE` is discarded and raises `usr_drop` one cycle later.
- `DONE`: lasts one cycle, `done` = 1, then the block returns to `IDLE`.
- `start` while `busy` is high is ignored.
- `cnt` is `$clog2(DEPTH_MEM)` bits and is zero-extended to `ADDR_W`; it never wraps within a pass.
- `init_valid` low in `FILL` stalls the fill with no timeout; `cnt` holds.
- User write addresses >= `DEPTH_MEM` are forwarded unchanged. Range checking is the RAM's concern.
- `mem_raddr` = `usr_raddr` combinationally in all states. Reads during `FILL` return whatever the RAM currently holds: old or new contents, with no guarantee.

## Timing
- `mem_we`, `mem_waddr`, `mem_din`, `usr_drop`, `busy` and `done` are registered. A write request or accepted init beat in cycle N appears on `mem_*` in cycle N+1.
- `start` sampled in cycle N:
  - `busy` = 1 and `init_ready` = 1 from cycle N+1.
  - The first init beat is accepted no earlier than N+1.
- Last beat accepted in cycle M:
  - Its RAM write appears in M+1.
  - `done` = 1 in M+1.
  - `busy` = 0 in M+2; user writes are forwarded again from M+2.
- `start` and `usr_we` in the same `IDLE` cycle: the user write is forwarded (N+1), then the fill begins. No drop.
- Reset values: state `IDLE`, `cnt` 0, `busy` 0, `done` 0, `init_ready` 0, `usr_drop` 0, `mem_we` 0, `mem_waddr` 0, `mem_din` 0.
- Reset asserted mid-fill aborts immediately. RAM contents are then partially reinitialized; a new `start` is required.

## Configuration
- Macro `MEM_REINIT_DROPCNT_EN`:
  - Defined: adds output `drop_cnt` (16 bits). It counts discarded user writes, saturates at 0xFFFF, clears on reset and on each accepted `start`, and updates in the same cycle as `usr_drop`.
  - Undefined: no `drop_cnt` port and no counter logic; all other behaviour is identical.

## Structure
- Package `mem_reinit_pkg`:
  - state enum `reinit_state_t` {IDLE, FILL, DONE}
  - constant `MEM_ADDR_W` = 32
  - constant `DROPCNT_W` = 16
- One sub-module: `mem_reinit_addr_gen`, the fill address counter. Inputs: clear, advance. Outputs: `cnt` and a `last` flag (`cnt` == `DEPTH_MEM`-1).
- The RAM itself is instantiated beside this block in the design top, not inside it.

## Test plan
Bench configuration: `WID_MEM` = 3, `DEPTH_MEM` = 16.
- Reset, then idle user write addr 5 data 3 -> `mem_we` = 1, `mem_waddr` = 5, `mem_din` = 3 one cycle later; read of addr 5 returns 3.
- `start`, continuous `init_valid` with data = addr mod 8 -> `init_ready` high from N+1; writes at addresses 0..15 on consecutive cycles; `done` in the cycle of the write to 15; `busy` low the next cycle; readback matches.
- Fill with `init_valid` toggling every other cycle -> exactly 16 writes, no skipped or duplicate address, `done` after the 16th beat.
- `usr_we` pulses at cycles 3 and 7 of the fill -> `usr_drop` pulses one cycle after each; no user data reaches the RAM; with `MEM_REINIT_DROPCNT_EN`, `drop_cnt` = 2.
- Second `start` mid-fill -> ignored, `cnt` continues. Reset asserted after 6 beats -> all outputs return to reset values immediately; a new `start` refills from address 0.
- `start` together with `usr_we` (addr 9, data 1) in `IDLE` -> user write forwarded, no `usr_drop`, fill then overwrites addr 9 with its init word.

Source files
------------

// File: rtl/mem_reinit_pkg.sv
// Shared types and constants for the RAM write-port reinitialization controller.
package mem_reinit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } reinit_state_t;

  localparam int MEM_ADDR_W = 32;
  localparam int DROPCNT_W  = 16;

  function automatic logic [DROPCNT_W-1:0] sat_inc(input logic [DROPCNT_W-1:0] v);
    return (&v) ? v : v + DROPCNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_reinit_addr_gen.sv
// Fill address counter: cleared on an accepted start, stepped on each accepted init beat.
module mem_reinit_addr_gen #(
  parameter int DEPTH_MEM = 4096,
  parameter int CNT_W     = $clog2(DEPTH_MEM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(DEPTH_MEM - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance && !last) begin
      // Holding at the top address keeps the counter from wrapping inside a pass.
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_reinit_ctrl.sv
// Arbitrates the RAM write port between user writes and a full-image reinit stream.
// Optional MEM_REINIT_DROPCNT_EN adds a saturating count of discarded user writes.
module mem_reinit_ctrl
  import mem_reinit_pkg::*;
#(
  parameter int WID_MEM   = 3,
  parameter int DEPTH_MEM = 4096,
  parameter int ADDR_W    = MEM_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               init_valid,
  output logic               init_ready,
  input  logic [WID_MEM-1:0] init_data,
  input  logic               usr_we,
  input  logic [ADDR_W-1:0]  usr_waddr,
  input  logic [WID_MEM-1:0] usr_din,
  output logic               usr_drop,
  input  logic [ADDR_W-1:0]  usr_raddr,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic [ADDR_W-1:0]  mem_raddr
`ifdef MEM_REINIT_DROPCNT_EN
  ,
  output logic [DROPCNT_W-1:0] drop_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH_MEM);

  reinit_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             start_acc;
  logic             beat;
  logic             drop_now;

  assign start_acc  = (state == IDLE) && start;
  assign beat       = (state == FILL) && init_valid;
  assign drop_now   = usr_we && (state != IDLE);
  assign init_ready = (state == FILL);
  assign mem_raddr  = usr_raddr;

  mem_reinit_addr_gen #(
    .DEPTH_MEM (DEPTH_MEM),
    .CNT_W     (CNT_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_acc),
    .advance (beat),
    .cnt     (cnt),
    .last    (last)
  );

  // NOTE: the default at the top of the block keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (beat && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      usr_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      usr_drop <= drop_now;
    end
  end

  // Address and data only move on a real write; they hold otherwise to avoid needless toggling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_din   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (state == IDLE && usr_we) begin
        mem_we    <= 1'b1;
        mem_waddr <= usr_waddr;
        mem_din   <= usr_din;
      end else if (beat) begin
        mem_we    <= 1'b1;
        mem_waddr <= ADDR_W'(cnt);
        mem_din   <= init_data;
      end
    end
  end

`ifdef MEM_REINIT_DROPCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (start_acc) begin
      drop_cnt <= '0;
    end else if (drop_now) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// Self-checking bench for mem_reinit_ctrl: directed scenarios plus random traffic against a transaction model.
module tb_mem_reinit_ctrl;

  localparam int WID   = 3;
  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int IW    = $clog2(DEPTH);

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           start;
  logic           busy;
  logic           done;
  logic           init_valid;
  logic           init_ready;
  logic [WID-1:0] init_data;
  logic           usr_we;
  logic [AW-1:0]  usr_waddr;
  logic [WID-1:0] usr_din;
  logic           usr_drop;
  logic [AW-1:0]  usr_raddr;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [WID-1:0] mem_din;
  logic [AW-1:0]  mem_raddr;
`ifdef MEM_REINIT_DROPCNT_EN
  logic [15:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  mem_reinit_ctrl #(
    .WID_MEM   (WID),
    .DEPTH_MEM (DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .init_valid (init_valid),
    .init_ready (init_ready),
    .init_data  (init_data),
    .usr_we     (usr_we),
    .usr_waddr  (usr_waddr),
    .usr_din    (usr_din),
    .usr_drop   (usr_drop),
    .usr_raddr  (usr_raddr),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_din    (mem_din),
    .mem_raddr  (mem_raddr)
`ifdef MEM_REINIT_DROPCNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  // Behavioural RAM beside the controller, registered read.
  logic [WID-1:0] ram [DEPTH];
  logic [WID-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_we && mem_waddr < AW'(DEPTH)) ram[mem_waddr[IW-1:0]] <= mem_din;
    ram_q <= ram[mem_raddr[IW-1:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  // Transaction model: busy/done phase, fill position, drop tally, expected RAM image.
  bit             m_busy, m_done;
  int             m_cnt, m_drops;
  logic [WID-1:0] exp_mem [DEPTH];
  bit             exp_known [DEPTH];
  bit             pend_v;
  int             pend_a;
  logic [WID-1:0] pend_d;

  task automatic idle_inputs();
    start      = 1'b0;
    init_valid = 1'b0;
    init_data  = '0;
    usr_we     = 1'b0;
    usr_waddr  = '0;
    usr_din    = '0;
    usr_raddr  = '0;
  endtask

  // One clock: predict from current inputs, advance, compare registered outputs.
  task automatic tick();
    bit             e_we, e_drop, fill;
    logic [AW-1:0]  e_waddr;
    logic [WID-1:0] e_din;
    #1;
    fill = m_busy && !m_done;
    check("init_ready", 32'(init_ready), 32'(fill));
    check("mem_raddr", mem_raddr, usr_raddr);
    if (pend_v) begin
      exp_mem[pend_a]   = pend_d;
      exp_known[pend_a] = 1'b1;
    end
    pend_v  = 1'b0;
    e_drop  = usr_we && m_busy;
    e_we    = 1'b0;
    e_waddr = '0;
    e_din   = '0;
    if (!m_busy) begin
      e_we    = usr_we;
      e_waddr = usr_waddr;
      e_din   = usr_din;
      if (start) begin
        m_busy  = 1'b1;
        m_done  = 1'b0;
        m_cnt   = 0;
        m_drops = 0;
      end
    end else if (fill) begin
      e_we    = init_valid;
      e_waddr = AW'(m_cnt);
      e_din   = init_data;
      if (init_valid) begin
        if (m_cnt == DEPTH - 1) m_done = 1'b1;
        else m_cnt++;
      end
    end else begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end
    if (e_drop && m_drops < 65535) m_drops++;
    if (e_we && e_waddr < AW'(DEPTH)) begin
      pend_v = 1'b1;
      pend_a = int'(e_waddr);
      pend_d = e_din;
    end
    @(posedge clk);
    #1;
    check("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we) begin
      check("mem_waddr", mem_waddr, e_waddr);
      check("mem_din", 32'(mem_din), 32'(e_din));
    end
    check("usr_drop", 32'(usr_drop), 32'(e_drop));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
`ifdef MEM_REINIT_DROPCNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_init_ready", 32'(init_ready), 32'd0);
    check("rst_usr_drop", 32'(usr_drop), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_waddr", mem_waddr, 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
`ifdef MEM_REINIT_DROPCNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_cnt   = 0;
    m_drops = 0;
    pend_v  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic read_check(input int addr);
    usr_raddr = AW'(addr);
    tick();
    if (exp_known[addr]) check($sformatf("readback[%0d]", addr), 32'(ram_q), 32'(exp_mem[addr]));
  endtask

  task automatic readback_all();
    idle_inputs();
    tick();
    tick();
    for (int a = 0; a < DEPTH; a++) read_check(a);
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid/data.
  // inject: user writes at fill cycles 3 and 7, plus a second start at cycle 5.
  task automatic run_fill(input int mode, input bit inject);
    int nwr = 0;
    int ndrop = 0;
    int k = 0;
    start = 1'b1;
    tick();
    idle_inputs();
    while (m_busy && k < 200) begin
      case (mode)
        0:       init_valid = 1'b1;
        1:       init_valid = (k % 2 == 0);
        default: init_valid = 1'($urandom);
      endcase
      init_data = (mode == 2) ? WID'($urandom) : WID'(m_cnt % 8);
      usr_we    = inject && (k == 3 || k == 7);
      usr_waddr = AW'($urandom % DEPTH);
      usr_din   = WID'($urandom);
      start     = inject && (k == 5);
      tick();
      nwr   += int'(mem_we);
      ndrop += int'(usr_drop);
      k++;
    end
    idle_inputs();
    check("fill_end_busy", 32'(busy), 32'd0);
    check("fill_writes", 32'(nwr), 32'(DEPTH));
    if (inject) check("fill_drops", 32'(ndrop), 32'd2);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) exp_known[a] = 1'b0;
    idle_inputs();
    #2;
    do_reset();

    // Idle user write forwarded, then read back.
    usr_we    = 1'b1;
    usr_waddr = 32'd5;
    usr_din   = 3'd3;
    tick();
    idle_inputs();
    tick();
    tick();
    read_check(5);
    check("idle_wr_readback", 32'(ram_q), 32'd3);

    run_fill(0, 1'b0);
    readback_all();
    run_fill(1, 1'b0);
    readback_all();
    run_fill(0, 1'b1);
    readback_all();

    // Abort after six accepted beats, then a clean refill from address 0.
    start = 1'b1;
    tick();
    idle_inputs();
    init_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      init_data = WID'($urandom);
      tick();
    end
    do_reset();
    run_fill(2, 1'b0);
    readback_all();

    // start together with a user write to address 9.
    start     = 1'b1;
    usr_we    = 1'b1;
    usr_waddr = 32'd9;
    usr_din   = 3'd1;
    run_fill(2, 1'b0);
    readback_all();

    // Random traffic across all phases.
    for (int i = 0; i < 400; i++) begin
      start      = ($urandom % 16 == 0);
      usr_we     = ($urandom % 3 == 0);
      usr_waddr  = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom % DEPTH);
      usr_din    = WID'($urandom);
      init_valid = 1'($urandom);
      init_data  = WID'($urandom);
      usr_raddr  = AW'($urandom % DEPTH);
      tick();
    end
    idle_inputs();
    init_valid = 1'b1;
    for (int i = 0; i < 40 && m_busy; i++) begin
      init_data = WID'($urandom);
      tick();
    end
    check("drain_busy", 32'(busy), 32'd0);
    readback_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
